// File: rtl/uart_cmd_bridge.sv
// ============================================================================
// uart_cmd_bridge : framed UART command decoder driving an 8-bit register bus.
// Optional macro UART_BRIDGE_WRACK_EN : acknowledge each completed write with 8'h06.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_cmd_bridge #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd48000,
    parameter logic [7:0]  CMD_WR         = 8'h57,
    parameter logic [7:0]  CMD_RD         = 8'h52,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] RxBuf,
    input  logic       RxRdy,
    input  logic       RxErr,
    output logic       Read_RxBuf,
    output logic [7:0] TxBuf,
    output logic       Write_TxBuf,
    input  logic       TxEmpty,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic [7:0] err_cnt
);

`ifdef UART_BRIDGE_WRACK_EN
    localparam logic [7:0] ACK_BYTE = 8'h06;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_BUS_WR   = 3'd3,
        S_BUS_RD   = 3'd4,
        S_RD_WAIT  = 3'd5,
        S_TX_SEND  = 3'd6
    } state_t;

    state_t      state;
    logic        rx_hold;
    logic        cmd_is_wr;
    logic [15:0] tmo_cnt;
    logic        rx_state;
    logic        take;
    logic        tmo_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // rx_hold masks the cycle where the UART still shows RxRdy after our pop.
    assign rx_state = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign take     = rx_state && RxRdy && !rx_hold;
    assign tmo_hit  = (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            rx_hold     <= 1'b0;
            cmd_is_wr   <= 1'b0;
            tmo_cnt     <= 16'd0;
            Read_RxBuf  <= 1'b0;
            Write_TxBuf <= 1'b0;
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
            TxBuf       <= 8'd0;
            bus_addr    <= 8'd0;
            bus_wdata   <= 8'd0;
            err_cnt     <= 8'd0;
        end else begin
            Read_RxBuf  <= take;
            rx_hold     <= take;
            Write_TxBuf <= 1'b0;
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
            tmo_cnt     <= 16'd0;

            if (take && RxErr) begin
                // A corrupted byte aborts whatever frame is in progress.
                err_cnt <= sat_inc(err_cnt);
                TxBuf   <= NAK_BYTE;
                state   <= S_TX_SEND;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (take) begin
                            if (RxBuf == CMD_WR || RxBuf == CMD_RD) begin
                                cmd_is_wr <= (RxBuf == CMD_WR);
                                state     <= S_GET_ADDR;
                            end else begin
                                TxBuf <= NAK_BYTE;
                                state <= S_TX_SEND;
                            end
                        end
                    end
                    S_GET_ADDR: begin
                        if (take) begin
                            bus_addr <= RxBuf;
                            state    <= cmd_is_wr ? S_GET_DATA : S_BUS_RD;
                        end else if (tmo_hit) begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    S_GET_DATA: begin
                        if (take) begin
                            bus_wdata <= RxBuf;
                            state     <= S_BUS_WR;
                        end else if (tmo_hit) begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    S_BUS_WR: begin
                        bus_we <= 1'b1;
`ifdef UART_BRIDGE_WRACK_EN
                        TxBuf  <= ACK_BYTE;
                        state  <= S_TX_SEND;
`else
                        state  <= S_IDLE;
`endif
                    end
                    S_BUS_RD: begin
                        bus_re <= 1'b1;
                        state  <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        TxBuf <= bus_rdata;
                        state <= S_TX_SEND;
                    end
                    S_TX_SEND: begin
                        if (TxEmpty) begin
                            Write_TxBuf <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
// ============================================================================
// tb_uart_cmd_bridge : directed and randomized frames against a register-file model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_bridge;

    localparam int TMO = 300;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] RxBuf = 8'd0;
    logic       RxRdy = 1'b0;
    logic       RxErr = 1'b0;
    logic       Read_RxBuf;
    logic [7:0] TxBuf;
    logic       Write_TxBuf;
    logic       TxEmpty = 1'b1;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'd0;
    logic       busy;
    logic [7:0] err_cnt;

    uart_cmd_bridge #(.TIMEOUT_CYCLES(16'(TMO))) dut (
        .clk(clk), .Reset(Reset), .RxBuf(RxBuf), .RxRdy(RxRdy), .RxErr(RxErr),
        .Read_RxBuf(Read_RxBuf), .TxBuf(TxBuf), .Write_TxBuf(Write_TxBuf),
        .TxEmpty(TxEmpty), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

`ifdef UART_BRIDGE_WRACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];   // expected register contents
    logic [7:0]  rf  [256];   // register file driven by the DUT's bus
    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    logic [7:0]  tx_q [$];
    int          pop_cnt = 0;
    int          dbl_cnt = 0;
    int          exp_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus/Tx monitor and register-file responder
    initial begin
        logic p_rd, p_we, p_re, p_tx;
        p_rd = 0; p_we = 0; p_re = 0; p_tx = 0;
        forever begin
            @(negedge clk);
            if (!Reset) begin
                if (Read_RxBuf) pop_cnt++;
                if (bus_we) begin
                    we_q.push_back({bus_addr, bus_wdata});
                    rf[bus_addr] = bus_wdata;
                end
                if (bus_re) begin
                    re_q.push_back(bus_addr);
                    bus_rdata = rf[bus_addr];
                end
                if (Write_TxBuf) tx_q.push_back(TxBuf);
                if ((p_rd && Read_RxBuf) || (p_we && bus_we) || (p_re && bus_re) || (p_tx && Write_TxBuf))
                    dbl_cnt++;
            end
            p_rd = Read_RxBuf; p_we = bus_we; p_re = bus_re; p_tx = Write_TxBuf;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mon();
        we_q.delete(); re_q.delete(); tx_q.delete();
        pop_cnt = 0;
    endtask

    // UART model: present a byte, hold RxRdy through the cycle after the pop
    task automatic send_byte(input logic [7:0] b, input logic e);
        int n;
        @(negedge clk);
        RxBuf = b; RxErr = e; RxRdy = 1'b1;
        n = 0;
        while (Read_RxBuf !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("rx_pop", {31'd0, Read_RxBuf}, 32'd1);
        @(posedge clk);
        #1;
        RxRdy = 1'b0; RxErr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        clear_mon();
        send_byte(8'h57, 1'b0);
        send_byte(a, 1'b0);
        send_byte(d, 1'b0);
        wait_idle();
        mem[a] = d;
        check("wr_count", we_q.size(), 1);
        check("wr_addr_data", (we_q.size() > 0) ? we_q[0] : 16'hxxxx, {a, d});
        check("wr_no_re", re_q.size(), 0);
        check("wr_pops", pop_cnt, 3);
        check("wr_ack_count", tx_q.size(), ACK_EN ? 1 : 0);
        if (tx_q.size() > 0) check("wr_ack_byte", tx_q[0], 8'h06);
    endtask

    task automatic do_read(input logic [7:0] a, input int dly);
        clear_mon();
        TxEmpty = (dly == 0);
        send_byte(8'h52, 1'b0);
        send_byte(a, 1'b0);
        repeat (dly) @(negedge clk);
        check("rd_tx_held", tx_q.size(), 0);
        TxEmpty = 1'b1;
        wait_idle();
        check("rd_re_count", re_q.size(), 1);
        check("rd_addr", (re_q.size() > 0) ? re_q[0] : 8'hxx, a);
        check("rd_tx_count", tx_q.size(), 1);
        check("rd_data", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, mem[a]);
        check("rd_no_we", we_q.size(), 0);
        check("rd_pops", pop_cnt, 2);
    endtask

    task automatic do_nak(input logic [7:0] b, input logic e);
        clear_mon();
        send_byte(b, e);
        wait_idle();
        if (e) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        check("nak_count", tx_q.size(), 1);
        check("nak_byte", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h15);
        check("nak_no_bus", we_q.size() + re_q.size(), 0);
        check("nak_err_cnt", err_cnt, exp_err);
    endtask

    initial begin
        logic [7:0] a, d, b;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            rf[i]  = mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_read_rxbuf", Read_RxBuf, 0);
        check("rst_write_txbuf", Write_TxBuf, 0);
        check("rst_strobes", {bus_we, bus_re}, 0);
        check("rst_txbuf", TxBuf, 0);
        check("rst_addr_wdata", {bus_addr, bus_wdata}, 0);
        check("rst_err_busy", {err_cnt, busy}, 0);
        Reset = 1'b0;

        // Directed write and read with a Tx stall
        do_write(8'h10, 8'hA5);
        mem[8'h3C] = 8'hC3; rf[8'h3C] = 8'hC3;
        do_read(8'h3C, 20);

        // Bad command, then a normal read
        do_nak(8'h41, 1'b0);
        do_read(8'h00, 0);

        // Timeout inside a partial frame
        clear_mon();
        send_byte(8'h57, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_still_busy", busy, 1);
        @(negedge clk);
        check("tmo_idle", busy, 0);
        exp_err++;
        repeat (3) @(negedge clk);
        check("tmo_err_cnt", err_cnt, exp_err);
        check("tmo_no_activity", we_q.size() + re_q.size() + tx_q.size(), 0);
        do_read(8'h01, 0);

        // Receive error mid-frame, then saturate the error counter
        clear_mon();
        send_byte(8'h57, 1'b0);
        do_nak(8'h22, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'($urandom), 1'b1);
            wait_idle();
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        check("err_saturated", err_cnt, 8'hFF);
        check("err_model", err_cnt, exp_err);

        // Reset mid-frame
        clear_mon();
        send_byte(8'h57, 1'b0);
        send_byte(8'h10, 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_outputs", {Read_RxBuf, Write_TxBuf, bus_we, bus_re}, 0);
        check("midrst_regs", {TxBuf, bus_addr, bus_wdata}, 0);
        check("midrst_err_busy", {err_cnt, busy}, 0);
        @(negedge clk);
        Reset = 1'b0;
        exp_err = 0;
        do_nak(8'hA5, 1'b0);

        // Randomized traffic against the register model
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                do_nak(b, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 1) == 0) begin
                do_write(a, d);
            end else begin
                do_read(a, $urandom_range(0, 5));
            end
        end

        check("no_double_pulse", dbl_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Byte-protocol command decoder downstream of the 8-bit UART. Consumes received bytes via the UART RxBuf/RxRdy/Read_RxBuf handshake.
- Turns framed commands into single-cycle accesses on a simple 8-bit register bus. Returns read data and status bytes through TxBuf/Write_TxBuf.
- Sits between the UART and the register file as the host-access path.

Parameters:
- TIMEOUT_CYCLES, 16'd48000, inter-byte timeout in clk cycles (3 ms at 16 MHz); applies only inside a partial frame.
- CMD_WR, 8'h57, command byte for a write ('W').
- CMD_RD, 8'h52, command byte for a read ('R').
- NAK_BYTE, 8'h15, response to a bad command or a receive error.

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- RxBuf  in  8  received byte from UART
- RxRdy  in  1  UART byte available
- RxErr  in  1  UART frame/overrun error flag
- Read_RxBuf  out  1  one-cycle pop pulse to UART
- TxBuf  out  8  response byte to UART
- Write_TxBuf  out  1  one-cycle write pulse to UART
- TxEmpty  in  1  UART transmit buffer free
- bus_addr  out  8  register address
- bus_wdata  out  8  write data
- bus_we  out  1  one-cycle write strobe
- bus_re  out  1  one-cycle read strobe
- bus_rdata  in  8  read data, valid exactly 1 cycle after bus_re
- busy  out  1  high whenever state != IDLE
- err_cnt  out  8  saturating count of aborted frames

Behaviour:
- Reset and clock: Reset is synchronous, active-high; clock is clk. All logic is on posedge clk.
- Reset values: state=IDLE; Read_RxBuf=0, Write_TxBuf=0, bus_we=0, bus_re=0; TxBuf=0, bus_addr=0, bus_wdata=0; err_cnt=0; busy=0; timeout counter=0; rx_hold=0.
- Rx pop rule:
  - take = RxRdy & !rx_hold, evaluated only in IDLE, GET_ADDR and GET_DATA.
  - On take: Read_RxBuf=1 for one cycle; capture RxBuf and RxErr in the same cycle; set rx_hold for the next cycle. RxRdy falls one cycle after the pop, so this prevents a double pop.
  - In all other states no pop occurs; bytes wait in the UART as backpressure.
- Error on pop: if RxErr=1 at a take, discard the byte, err_cnt+=1, go to TX_SEND with NAK_BYTE, whatever the state.
- IDLE:
  - take of CMD_WR or CMD_RD: latch the command, go to GET_ADDR, clear the timeout counter.
  - take of any other byte: go to TX_SEND with NAK_BYTE. err_cnt is not incremented.
- GET_ADDR, on take: bus_addr<=byte.
  - CMD_WR: go to GET_DATA.
  - CMD_RD: go to BUS_RD.
- GET_DATA, on take: bus_wdata<=byte, go to BUS_WR.
- BUS_WR: bus_we=1 for one cycle.
  - With UART_BRIDGE_WRACK_EN: go to TX_SEND with 8'h06.
  - Without it: go to IDLE.
- BUS_RD: bus_re=1 for one cycle, go to RD_WAIT.
- RD_WAIT: TxBuf<=bus_rdata, go to TX_SEND.
- TX_SEND:
  - Wait until TxEmpty=1, then pulse Write_TxBuf for one cycle with TxBuf stable, then go to IDLE.
  - TxBuf holds its value until the next response.
- Timeout:
  - 16-bit counter increments each cycle in GET_ADDR and GET_DATA; cleared on every take and in every other state.
  - When the count reaches TIMEOUT_CYCLES-1 with no take: go to IDLE, err_cnt+=1, send no response.
  - A take in the same cycle as the terminal count wins: the byte is accepted and there is no timeout.
- err_cnt saturates at 8'hFF with no wrap.
- Latencies:
  - Read: last address byte pop to bus_re is 1 cycle; bus_re to TxBuf valid is 1 cycle; Write_TxBuf follows in the next cycle if TxEmpty=1.
  - Write: data byte pop to bus_we is 1 cycle.
- Reset mid-frame: the partial frame is dropped, no bus strobe and no Tx pulse are emitted, and err_cnt is cleared.

Optional Feature:
- Macro: UART_BRIDGE_WRACK_EN.
- Defined: every completed write returns ACK byte 8'h06 through TX_SEND after bus_we.
- Undefined: writes are silent; BUS_WR returns directly to IDLE and the TX path is used only for read data and NAK.

Test Plan:
- Write: RxRdy bytes 57,10,A5 (RxRdy cleared 1 cycle after each Read_RxBuf) -> exactly one bus_we with bus_addr=10, bus_wdata=A5; three single-cycle Read_RxBuf pulses; with WRACK_EN, one Write_TxBuf with TxBuf=06, otherwise none.
- Read: bytes 52,3C; bench returns bus_rdata=C3 one cycle after bus_re -> bus_re once with bus_addr=3C; TxEmpty=0 for 20 cycles delays Write_TxBuf until TxEmpty=1; Write_TxBuf pulses once with TxBuf=C3.
- Bad command: byte 41 -> Write_TxBuf with TxBuf=15, err_cnt stays 0, returns to IDLE; a following 52,00 read completes normally.
- Timeout: byte 57, then no byte for TIMEOUT_CYCLES cycles -> back to IDLE, err_cnt=1, no bus strobe, no Tx; next 52,01 read works.
- RxErr: bytes 57, then 22 with RxErr=1 -> no bus_we, TxBuf=15 sent, err_cnt=1; 256 further RxErr frames leave err_cnt=FF.
- Reset mid-frame: Reset asserted after 57,10 -> all outputs at reset values next cycle; a later data byte A5 alone gives NAK, not a write.
